// File: rtl/operand_pkg.sv
// Shared constants and types for the operand-fetch slice: SPARC field positions,
// datapath sizing and the latched operand bundle.
package operand_pkg;
  localparam int DW        = 32;
  localparam int NREG      = 32;
  localparam int RS1_HI    = 18;
  localparam int RS1_LO    = 14;
  localparam int RS2_HI    = 4;
  localparam int RS2_LO    = 0;
  localparam int RD_HI     = 29;
  localparam int RD_LO     = 25;
  localparam int IBIT      = 13;
  localparam int IMM22_HI  = 21;
  localparam int SIMM13_HI = 12;

  typedef struct packed {
    logic [DW-1:0] is;
    logic [DW-1:0] r;
    logic [DW-1:0] rs1;
  } bundle_t;
endpackage

// File: rtl/register_file_32x32.sv
// Integer register file: two combinational read ports, one clocked write port,
// r0 reads as zero and is never written.
module register_file_32x32 #(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [$clog2(N)-1:0] ra1,
  input  logic [$clog2(N)-1:0] ra2,
  output logic [W-1:0]         rd1,
  output logic [W-1:0]         rd2,
  input  logic                 we,
  input  logic [$clog2(N)-1:0] wa,
  input  logic [W-1:0]         wd
);
  logic [N-1:0][W-1:0] mem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 mem     <= '0;
    else if (we && wa != '0)   mem[wa] <= wd;
  end

  assign rd1 = (ra1 == '0) ? '0 : mem[ra1];
  assign rd2 = (ra2 == '0) ? '0 : mem[ra2];
endmodule

// File: rtl/operand_fetch_stage.sv
// Single-entry operand fetch register: latches the instruction, reads rs1/rs2 and
// keeps the held operands coherent with write-back until execute consumes them.
module operand_fetch_stage #(
  parameter int NREG = 32,
  parameter int DW   = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] in_instr,
  output logic          in_ready,
  input  logic          wb_we,
  input  logic [4:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] IS,
  output logic [DW-1:0] R,
  output logic [DW-1:0] RS1,
  output logic [21:0]   Imm
);
  import operand_pkg::*;

  localparam int AW = $clog2(NREG);

  bundle_t       bq;
  logic [AW-1:0] rs1_a, rs2_a, h_rs1, h_rs2;
  logic [DW-1:0] rf_rd1, rf_rd2;
  logic          cap, wb_hit;

  assign rs1_a = in_instr[RS1_HI:RS1_LO];
  assign rs2_a = in_instr[RS2_HI:RS2_LO];
  assign h_rs1 = bq.is[RS1_HI:RS1_LO];
  assign h_rs2 = bq.is[RS2_HI:RS2_LO];

  assign in_ready = !out_valid || out_ready;
  assign cap      = in_valid && in_ready;
  assign wb_hit   = wb_we && (wb_rd != '0);

  register_file_32x32 #(.N(NREG), .W(DW)) u_rf (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1_a),
    .ra2   (rs2_a),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2),
    .we    (wb_we),
    .wa    (wb_rd),
    .wd    (wb_data)
  );

  // The array write lands on the same edge as capture, so forward it here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bq        <= '0;
      out_valid <= 1'b0;
    end else if (cap) begin
      bq.is     <= in_instr;
      bq.rs1    <= (wb_hit && wb_rd == rs1_a) ? wb_data : rf_rd1;
      bq.r      <= (wb_hit && wb_rd == rs2_a) ? wb_data : rf_rd2;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      // Stalled bundle tracks later write-backs to its source registers.
      if (wb_hit && wb_rd == h_rs1) bq.rs1 <= wb_data;
      if (wb_hit && wb_rd == h_rs2) bq.r   <= wb_data;
    end
  end

  assign IS  = bq.is;
  assign R   = bq.r;
  assign RS1 = bq.rs1;
  assign Imm = bq.is[IMM22_HI:0];
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench: stimulus queues hand-computed bundles, a negedge monitor
// compares each bundle as execute accepts it.
module tb_operand_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, wb_we, out_valid, out_ready;
  logic [31:0] in_instr, wb_data, IS, R, RS1;
  logic [4:0]  wb_rd;
  logic [21:0] Imm;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] is;
    logic [31:0] r;
    logic [31:0] rs1;
  } exp_t;
  exp_t q[$];
  exp_t me;

  logic [31:0] b2b_ins [4] = '{32'h0000C000, 32'h00014000, 32'h0001C000, 32'h00024000};
  logic [31:0] b2b_rs1 [4] = '{32'hE0000003, 32'hCAFEF00D, 32'hA5A5A5A5, 32'h00000042};

  operand_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_ready  (in_ready),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .IS        (IS),
    .R         (R),
    .RS1       (RS1),
    .Imm       (Imm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] is, input logic [31:0] r, input logic [31:0] rs1);
    exp_t e;
    e.is = is; e.r = r; e.rs1 = rs1;
    q.push_back(e);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_we = 1'b1; wb_rd = rd; wb_data = d;
    cyc();
    wb_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_bundle: got IS=%h expected none", IS);
      end else begin
        me = q.pop_front();
        chk("bundle_IS",  IS,  me.is);
        chk("bundle_R",   R,   me.r);
        chk("bundle_RS1", RS1, me.rs1);
        chk("bundle_Imm", 32'(Imm), 32'(me.is[21:0]));
      end
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; wb_we = 1'b0; wb_rd = '0;
    wb_data = '0; out_ready = 1'b0;
    #12 reset = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_IS",  IS,  32'd0);
    chk("rst_R",   R,   32'd0);
    chk("rst_RS1", RS1, 32'd0);
    chk("rst_Imm", 32'(Imm), 32'd0);
    cyc();

    wb(5'd0, 32'hFFFFFFFF);
    wb(5'd3, 32'hE0000003);
    wb(5'd5, 32'h12345678);
    wb(5'd7, 32'h11111111);

    // r0 read, with a same-cycle r0 write that must not forward
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0;
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    push(32'h0, 32'h0, 32'h0);
    cyc();
    wb_we = 1'b0;
    in_instr = 32'h8600C005;
    push(32'h8600C005, 32'h12345678, 32'hE0000003);
    cyc();
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    in_instr = 32'h8600C007;
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5A5A5;
    push(32'h8600C007, 32'hA5A5A5A5, 32'hE0000003);
    cyc();
    in_instr = 32'h00016003;
    wb_rd = 5'd5; wb_data = 32'hCAFEF00D;
    push(32'h00016003, 32'hE0000003, 32'hCAFEF00D);
    cyc();
    in_valid = 1'b0; wb_we = 1'b0;
    cyc(); cyc();
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // stall with refresh of held rs1, second instruction blocked
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00024005;
    push(32'h00024005, 32'hCAFEF00D, 32'h00000042);
    cyc();
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    in_instr = 32'h8600C005;
    wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h00000042;
    push(32'h8600C005, 32'hCAFEF00D, 32'hE0000003);
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    cyc();
    wb_we = 1'b0;
    chk("refresh_RS1", RS1, 32'h00000042);
    chk("refresh_IS",  IS,  32'h00024005);
    chk("refresh_R",   R,   32'hCAFEF00D);
    cyc();
    chk("stall_hold_IS", IS, 32'h00024005);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("release_IS", IS, 32'h8600C005);
    cyc();

    // back-to-back throughput
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_instr = b2b_ins[i];
      push(b2b_ins[i], 32'h0, b2b_rs1[i]);
      cyc();
      chk("b2b_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    cyc(); cyc();

    // asynchronous reset while a bundle is held
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h8600C005;
    cyc();
    in_valid = 1'b0;
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready",  32'(in_ready),  32'd1);
    chk("async_rst_IS",  IS,  32'd0);
    chk("async_rst_RS1", RS1, 32'd0);
    #3 reset = 1'b0;
    cyc();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h8600C005;
    push(32'h8600C005, 32'h0, 32'h0);
    cyc();
    in_valid = 1'b0;
    cyc(); cyc();

    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending bundles expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
